// File: rtl/adc_if_pkg.sv
// Shared ADC interface definitions: default sample width and width helpers.
package adc_if_pkg;

    localparam int unsigned ADC_WIDTH_DEFAULT = 10;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a counter holding 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_capture_fifo_sample_ram.sv
// DEPTH x WIDTH sample store: synchronous write with enable and reset,
// asynchronous read.
module sample_ram #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; reset zeroes every word so the head never reads X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port for first-word fall-through.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/adc_capture_fifo.sv
// ADC capture stage: optional decimation feeding a first-word-fall-through
// FIFO drained by a valid/ready handshake, with sticky overflow flag.
module adc_capture_fifo
    import adc_if_pkg::*;
#(
    parameter int unsigned WIDTH = ADC_WIDTH_DEFAULT,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DECIM = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [WIDTH-1:0]              a,
    output logic [WIDTH-1:0]              y,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    input  logic                          clear_ovf
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = level_width(DEPTH);
    localparam int unsigned DW = count_width(DECIM);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [DW-1:0] dcnt;
    logic          keep;
    logic          full;
    logic          rd;
    logic          wr;
    logic          drop;

    // Handshake and write/drop decisions from registered state only.
    always_comb begin
        keep = en && (dcnt == '0);
        full = (level == LW'(DEPTH));
        rd   = y_valid && y_ready;
        wr   = keep && (!full || rd);
        drop = keep && full && !rd;
    end

    // y_valid is decoded from the level register, so y_ready never reaches it.
    always_comb begin
        y_valid = (level != '0);
    end

    sample_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr),
        .waddr (wptr),
        .wdata (a),
        .raddr (rptr),
        .rdata (y)
    );

    // Decimation counter advances on every enabled sample, kept or dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt <= '0;
        end else if (en) begin
            if (dcnt == DW'(DECIM - 1)) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
        end
    end

    // Level tracks writes minus reads; simultaneous read+write holds it.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else if (wr && !rd) begin
            level <= level + LW'(1);
        end else if (rd && !wr) begin
            level <= level - LW'(1);
        end
    end

    // Sticky overflow; a new drop wins over clear_ovf.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Directed self-checking bench for adc_capture_fifo (DECIM=1 and DECIM=3).
module tb_adc_capture_fifo;

    logic       clk;
    logic       reset;
    logic       en;
    logic [9:0] a;
    logic       y_ready;
    logic       clear_ovf;

    logic [9:0] y;
    logic       y_valid;
    logic [3:0] level;
    logic       overflow;

    logic [9:0] y3;
    logic       y_valid3;
    logic [3:0] level3;
    logic       overflow3;

    int total;
    int bad;

    adc_capture_fifo #(.WIDTH(10), .DEPTH(8), .DECIM(1)) dut (
        .clk(clk), .reset(reset), .en(en), .a(a), .y(y), .y_valid(y_valid),
        .y_ready(y_ready), .level(level), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    adc_capture_fifo #(.WIDTH(10), .DEPTH(8), .DECIM(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .a(a), .y(y3), .y_valid(y_valid3),
        .y_ready(y_ready), .level(level3), .overflow(overflow3), .clear_ovf(clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; a = '0; y_ready = 1'b0; clear_ovf = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Write n samples base+1..base+n with no reads.
    task automatic fill(input int n, input int base);
        for (int i = 1; i <= n; i++) begin
            en = 1'b1; a = 10'(base + i); y_ready = 1'b0;
            step();
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; en = 1'b1; a = 10'h2AA;
        step();
        reset = 1'b0; idle();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", y_valid); end
        total++; if (y !== 10'h000) begin bad++; $display("FAIL reset_y got=%h exp=000", y); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        step();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_discard got=%0d exp=0", level); end
    endtask

    task automatic test_first_sample();
        do_reset();
        en = 1'b1; a = 10'h155; y_ready = 1'b0;
        step();
        idle();
        total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", y_valid); end
        total++; if (y !== 10'h155) begin bad++; $display("FAIL first_y got=%h exp=155", y); end
        total++; if (level !== 4'd1) begin bad++; $display("FAIL first_level got=%0d exp=1", level); end
    endtask

    task automatic test_overflow_drain();
        do_reset();
        fill(8, 0);
        total++; if (level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d exp=8", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_noovf got=%b exp=0", overflow); end
        en = 1'b1; a = 10'd9; step();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_9th got=%b exp=1", overflow); end
        en = 1'b1; a = 10'd10; step();
        idle();
        total++; if (level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", level); end
        y_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (y_valid !== 1'b1 || y !== 10'(i)) begin
                bad++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, y, y_valid, 10'(i));
            end
            step();
        end
        y_ready = 1'b0;
        total++; if (level !== 4'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", level); end
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", y_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_read_write();
        do_reset();
        fill(8, 10'h10);
        en = 1'b1; a = 10'h3FF; y_ready = 1'b1;
        step();
        idle();
        total++; if (level !== 4'd8) begin bad++; $display("FAIL fullrw_level got=%0d exp=8", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b exp=0", overflow); end
        y_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [9:0] exp;
            exp = (i == 7) ? 10'h3FF : 10'(10'h12 + i);
            total++;
            if (y !== exp) begin bad++; $display("FAIL fullrw_drain_%0d got=%h exp=%h", i, y, exp); end
            step();
        end
        idle();
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL fullrw_empty got=%b exp=0", y_valid); end
    endtask

    task automatic test_ovf_priority();
        do_reset();
        fill(8, 0);
        en = 1'b1; a = 10'h1; step();
        en = 1'b1; a = 10'h2; clear_ovf = 1'b1; step();
        idle();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_prio got=%b exp=1", overflow); end
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_prio_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        fill(5, 10'h40);
        total++; if (level !== 4'd5) begin bad++; $display("FAIL mid_level5 got=%0d exp=5", level); end
        reset = 1'b1; en = 1'b1; a = 10'h77;
        step();
        reset = 1'b0; idle();
        total++;
        if (level !== 4'd0 || y_valid !== 1'b0 || y !== 10'h0 || overflow !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%0d/%b/%h/%b exp=0/0/000/0", level, y_valid, y, overflow);
        end
        en = 1'b1; a = 10'h88; step(); idle();
        total++;
        if (y !== 10'h88 || level !== 4'd1) begin
            bad++; $display("FAIL mid_first got=%h/%0d exp=088/1", y, level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Write into empty FIFO with y_ready high: write only.
        en = 1'b1; a = 10'h100; y_ready = 1'b1;
        step();
        total++; if (level !== 4'd1 || y !== 10'h100) begin
            bad++; $display("FAIL b2b_first got=%0d/%h exp=1/100", level, y);
        end
        for (int i = 1; i <= 4; i++) begin
            en = 1'b1; a = 10'(10'h100 + i); y_ready = 1'b1;
            step();
            total++;
            if (level !== 4'd1 || y !== 10'(10'h100 + i)) begin
                bad++; $display("FAIL b2b_%0d got=%0d/%h exp=1/%h", i, level, y, 10'(10'h100 + i));
            end
        end
        idle();
    endtask

    task automatic test_decim();
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            en = 1'b1; a = 10'(i); y_ready = 1'b0;
            step();
        end
        idle();
        total++; if (level3 !== 4'd3) begin bad++; $display("FAIL decim_level got=%0d exp=3", level3); end
        y_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (y3 !== 10'(3 * i)) begin bad++; $display("FAIL decim_%0d got=%h exp=%h", i, y3, 10'(3 * i)); end
            step();
        end
        idle();
        // Gaps with en=0 must not advance the counter: keeps 10 and 13.
        do_reset();
        en = 1'b1; a = 10'd10; step();
        en = 1'b0; a = 10'd98; step();
        en = 1'b1; a = 10'd11; step();
        en = 1'b1; a = 10'd12; step();
        en = 1'b0; a = 10'd99; step();
        en = 1'b1; a = 10'd13; step();
        idle();
        total++; if (level3 !== 4'd2) begin bad++; $display("FAIL decim_gap_level got=%0d exp=2", level3); end
        total++; if (y3 !== 10'd10) begin bad++; $display("FAIL decim_gap_0 got=%0d exp=10", y3); end
        y_ready = 1'b1; step(); idle();
        total++; if (y3 !== 10'd13) begin bad++; $display("FAIL decim_gap_1 got=%0d exp=13", y3); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        idle();
        test_reset();
        test_first_sample();
        test_overflow_drain();
        test_full_read_write();
        test_ovf_priority();
        test_reset_midstream();
        test_back_to_back();
        test_decim();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_fifo.md
# adc_capture_fifo

Parametrised ADC sample capture stage that replaces the fixed 10-bit enable/reset register bank on the ADC interface path. It registers incoming ADC words on a capture enable, optionally decimates them, and buffers them in a small first-word-fall-through FIFO. Downstream logic drains the FIFO with a valid/ready handshake. It sits between the ADC data pins register and the sample processing/transfer logic.

## Interface

- WIDTH, 10, ADC sample width in bits (≥1)
- DEPTH, 8, FIFO depth in samples (power of two, ≥2)
- DECIM, 1, keep one of every DECIM enabled samples (≥1; 1 = no decimation)

- clk  input  1  single clock for all logic
- reset  input  1  synchronous, active-high; clears all state on the clk edge where it is high
- en  input  1  capture enable: `a` is a valid ADC sample this cycle
- a  input  WIDTH  ADC sample word
- y  output  WIDTH  FIFO head sample; valid only when y_valid=1
- y_valid  output  1  FIFO non-empty
- y_ready  input  1  consumer accepts `y` this cycle
- level  output  clog2(DEPTH)+1  number of stored samples, 0..DEPTH
- overflow  output  1  sticky: a kept sample was dropped because FIFO was full
- clear_ovf  input  1  clears `overflow`

## Operation

- Decimation counter dcnt (0..DECIM-1) advances only on cycles with en=1; wraps DECIM-1 → 0. Sample is "kept" when en=1 and dcnt=0. DECIM=1: every enabled sample kept.
- Write: kept sample written at tail if level<DEPTH, or if level=DEPTH and a read occurs in the same cycle (simultaneous read+write at full accepted, level unchanged).
- Kept sample with level=DEPTH and no read: dropped, overflow set; dcnt still advances.
- Read: occurs when y_valid=1 and y_ready=1; head pointer advances. y_ready ignored when y_valid=0.
- Simultaneous read+write at level 1..DEPTH-1: both performed, level unchanged.
- Write at level 0 with y_ready=1: write only (no read; y_valid was 0).
- Pointers wrap modulo DEPTH.
- overflow: set has priority over clear_ovf in the same cycle; otherwise clear_ovf=1 clears it.
- y is driven from storage at the head pointer (first-word fall-through); y content when y_valid=0 is don't-care but must not be X after reset (storage reset to 0).
- Reset: level=0, y_valid=0, y=0, overflow=0, dcnt=0, both pointers 0; sample presented with en=1 in the reset cycle is discarded. Reset mid-stream discards all buffered samples; first enabled sample after reset is kept.

## Timing

- Capture-to-output latency 1 cycle: kept sample at edge k into empty FIFO → y_valid=1, y=sample after edge k.
- level, y_valid, overflow all registered; update on the same edge as the write/read that changes them.
- Throughput: one write and one read per cycle sustained; FIFO at steady level with both active.
- No combinational path from y_ready to y_valid or y; y changes only on clock edges.

## Structure

- Shared package adc_if_pkg: default ADC width constant (10), clog2 function, level type width derivation.
- One sub-module: sample_ram — DEPTH×WIDTH register array, synchronous write with enable and synchronous reset, asynchronous read at an address; it is the parametrised generalisation of the per-bit enabled flop bank.
- Top holds pointers, level counter, decimation counter, overflow flag.

## Test plan

- Reset then en=1 with a=0x155, y_ready=0 → next cycle y_valid=1, y=0x155, level=1.
- DEPTH=8, write 10 samples 1..10 with y_ready=0 → level=8, overflow=1 after 9th sample; drain yields 1..8 in order, level=0, y_valid=0.
- Fill to 8, then one cycle en=1 (a=0x3FF) with y_ready=1 → level stays 8, overflow stays 0, 0x3FF read out last.
- DECIM=3, en=1 continuously with a=0,1,2,…,8 → FIFO receives 0,3,6; en=0 gaps do not advance dcnt.
- overflow set and clear_ovf=1 in same cycle as another drop → overflow remains 1; clear_ovf alone next cycle → 0.
- Level=5, assert reset one cycle mid-stream with en=1 → level=0, y_valid=0, overflow=0, y=0; next enabled sample appears first.
